// File: rtl/ddr_port_arbiter_if.sv
// Avalon-MM port bundle: the requester drives the master modport, the arbiter side uses slave.
// Same bundle serves both requester ports and the memory-side port of the arbiter.
interface ddr_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output addr, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  addr, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin share of one Avalon-MM DDR port between requesters A and B; read tags route data back.
// Command registered (grant->ddr_* 1 cycle), returns registered; ports stall on memory stall or full tag FIFO.
module ddr_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    ddr_port_arbiter_if.slave  a_if,
    ddr_port_arbiter_if.slave  b_if,
    ddr_port_arbiter_if.master ddr_if,
    output logic               err_orphan_o,
    output logic               err_proto_o
);
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING) + 1;

    typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   rd_q, rd_d, wr_q, wr_d;
    port_e                  owner_q, owner_d, rr_q, rr_d;
    logic [MAX_PENDING-1:0] tag_q;
    logic [PTR_W-1:0]       wptr_q, rptr_q;
    logic [CNT_W-1:0]       cnt_q, inflight;
    logic [DATA_W-1:0]      a_rdata_q, b_rdata_q;
    logic                   a_rdv_q, b_rdv_q, orphan_q, proto_q;
    logic                   slot_free, tag_push, tag_pop, rd_room;
    logic                   a_elig, b_elig, gnt_a, gnt_b;
    port_e                  ret_port;

    assign slot_free = !(rd_q || wr_q) || !ddr_if.waitrequest;
    assign tag_push  = rd_q && !ddr_if.waitrequest;
    assign tag_pop   = ddr_if.readdatavalid && (cnt_q != '0);
    assign ret_port  = port_e'(tag_q[rptr_q]);

    // A new read must still fit after this edge, including the held read being accepted now.
    assign inflight = cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
    assign rd_room  = inflight < CNT_W'(MAX_PENDING);

    assign a_elig = reset_n && (a_if.read || a_if.write) && slot_free && (a_if.write || rd_room);
    assign b_elig = reset_n && (b_if.read || b_if.write) && slot_free && (b_if.write || rd_room);
    assign gnt_a  = a_elig && (!b_elig || rr_q == PORT_B);
    assign gnt_b  = b_elig && (!a_elig || rr_q == PORT_A);

    assign a_if.waitrequest = !gnt_a;
    assign b_if.waitrequest = !gnt_b;

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        // Read+write together is taken as a write.
        if (gnt_a) begin
            addr_d  = a_if.addr;
            wr_d    = a_if.write;
            rd_d    = !a_if.write;
            owner_d = PORT_A;
            rr_d    = PORT_A;
            if (a_if.write) wdata_d = a_if.writedata;
        end else if (gnt_b) begin
            addr_d  = b_if.addr;
            wr_d    = b_if.write;
            rd_d    = !b_if.write;
            owner_d = PORT_B;
            rr_d    = PORT_B;
            if (b_if.write) wdata_d = b_if.writedata;
        end else if (slot_free) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            owner_q   <= PORT_A;
            rr_q      <= PORT_B;
            tag_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            a_rdv_q   <= 1'b0;
            b_rdv_q   <= 1'b0;
            orphan_q  <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_q + CNT_W'(tag_push) - CNT_W'(tag_pop);
            if (tag_push) begin
                tag_q[wptr_q] <= owner_q;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (tag_pop) rptr_q <= rptr_q + PTR_W'(1);
            a_rdv_q <= tag_pop && (ret_port == PORT_A);
            b_rdv_q <= tag_pop && (ret_port == PORT_B);
            if (tag_pop && ret_port == PORT_A) a_rdata_q <= ddr_if.readdata;
            if (tag_pop && ret_port == PORT_B) b_rdata_q <= ddr_if.readdata;
            if (ddr_if.readdatavalid && cnt_q == '0) orphan_q <= 1'b1;
            if ((a_if.read && a_if.write) || (b_if.read && b_if.write)) proto_q <= 1'b1;
        end
    end

    assign ddr_if.addr        = addr_q;
    assign ddr_if.read        = rd_q;
    assign ddr_if.write       = wr_q;
    assign ddr_if.writedata   = wdata_q;
    assign a_if.readdata      = a_rdata_q;
    assign a_if.readdatavalid = a_rdv_q;
    assign b_if.readdata      = b_rdata_q;
    assign b_if.readdatavalid = b_rdv_q;
    assign err_orphan_o       = orphan_q;
    assign err_proto_o        = proto_q;
endmodule

// File: doc/ddr_port_arbiter.md
Name: ddr_port_arbiter

Overview:
Two-requester round-robin arbiter that shares the single Avalon-MM DDR3 port (16-bit data, 32-bit word address) between a sample-capture writer/reader (port A) and the LPC analysis engine (port B). It presents an Avalon-MM slave interface to each requester and one master interface to the memory. It registers the issued command and tracks outstanding reads in a tag FIFO so that each readdatavalid is returned to the requester that issued the read. It never issues read and write in the same cycle.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 16, data width on all ports (signed data passed through unchanged)
MAX_PENDING, 4, depth of the outstanding-read tag FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
a_addr  in  ADDR_W  port A address
a_read  in  1  port A read request
a_write  in  1  port A write request
a_writedata  in  DATA_W  port A write data
a_waitrequest  out  1  port A stall, combinational
a_readdata  out  DATA_W  port A returned data, registered
a_readdatavalid  out  1  port A data strobe, registered
b_addr, b_read, b_write, b_writedata, b_waitrequest, b_readdata, b_readdatavalid: identical to port A, for port B
ddr_addr  out  ADDR_W  memory address, registered
ddr_read  out  1  memory read, registered
ddr_write  out  1  memory write, registered
ddr_writedata  out  DATA_W  memory write data, registered
ddr_waitrequest  in  1  memory stall
ddr_readdata  in  DATA_W  memory read data
ddr_readdatavalid  in  1  memory read strobe
err_orphan  out  1  sticky: readdatavalid arrived with empty tag FIFO
err_proto  out  1  sticky: a port asserted read and write together

Behaviour:
- Reset (async, reset_n low): all outputs 0 except a_waitrequest/b_waitrequest = 1 while reset asserted; tag FIFO emptied; rr pointer = B (so A wins first tie); errors cleared. In-flight reads are discarded; readdatavalid arriving in the first cycle after reset deassertion sets err_orphan.
- Slot free = no command held (ddr_read|ddr_write low) OR ddr_waitrequest low.
- Port eligible = (read|write) asserted AND slot free AND (for reads) tag FIFO not full, counting a same-cycle pop.
- Grant (combinational): one eligible -> it; both eligible -> port != rr pointer. Granted port sees waitrequest 0; all others 1.
- On grant at edge N: command registered onto ddr_* (visible cycle N+1); rr pointer <= granted port. Write: ddr_write=1, data/addr copied. Read: ddr_read=1.
- Slot free and no grant: ddr_read/ddr_write <= 0.
- ddr_waitrequest high: ddr_* held unchanged; no grant.
- Tag push (port id) when ddr_read=1 and ddr_waitrequest=0. Pop on ddr_readdatavalid; push and pop in the same cycle allowed, count unchanged.
- Return: on ddr_readdatavalid with popped tag T, port T readdata <= ddr_readdata and readdatavalid <= 1 for one cycle; the other port's readdatavalid stays 0. With memory latency 1, a read granted at edge N returns on the requester at edge N+3.
- readdatavalid with empty FIFO: data dropped, err_orphan <= 1 (sticky until reset).
- Port asserts read and write together: treated as write only, err_proto <= 1 (sticky).
- Back-to-back: a requester held continuously gets one command per cycle if alone; two continuous requesters alternate A,B,A,B.
- FIFO full: reads stall (waitrequest 1); writes still granted.

Test Plan:
- A writes 0x1234 to addr 5, then reads addr 5 -> ddr_write at N+1, ddr_read at N+2, a_readdatavalid=1 with a_readdata=0x1234 3 cycles after read grant; b_readdatavalid stays 0.
- A and B both hold reads (A addr 1=0x0011, B addr 2=0x0022) for 4 cycles -> ddr_addr sequence 1,2,1,2; returns alternate a/b with correct data, first grant to A.
- MAX_PENDING=2, memory stub delays readdatavalid 5 cycles, A issues 3 reads -> third read waitrequest=1 until the first data returns, then granted; all three returned in order.
- ddr_waitrequest forced high 3 cycles while a write is held -> ddr_* stable for 3 cycles, both ports waitrequest=1, command completes once, no duplicate write.
- Inject ddr_readdatavalid with no read outstanding -> err_orphan=1, no port readdatavalid; B asserts read+write to addr 7 -> write performed, err_proto=1.
- Assert reset_n low mid-read -> all outputs 0 immediately (waitrequests 1); after release, A wins first tie and the FIFO is empty.
